// File: rtl/btb_pkg.sv
// Shared types, counter encodings and PC field helpers for the tagged BTB.
package btb_pkg;

   localparam int unsigned BTB_XLEN     = 32;
   localparam int unsigned BTB_ENTRIES  = 64;
   localparam int unsigned BTB_CTR_BITS = 2;
   localparam int unsigned BTB_IDX_W    = $clog2(BTB_ENTRIES);
   localparam int unsigned BTB_TAG_W    = BTB_XLEN - BTB_IDX_W - 2;

   // Weak states sit either side of the counter midpoint (01 / 10 for two bits).
   localparam logic [BTB_CTR_BITS-1:0] CTR_WEAK_NT = {1'b0, {(BTB_CTR_BITS-1){1'b1}}};
   localparam logic [BTB_CTR_BITS-1:0] CTR_WEAK_T  = {1'b1, {(BTB_CTR_BITS-1){1'b0}}};

   typedef struct packed {
      logic                    valid;
      logic [BTB_TAG_W-1:0]    tag;
      logic [BTB_XLEN-1:0]     target;
      logic [BTB_CTR_BITS-1:0] ctr;
   } btb_entry_t;

   function automatic logic [63:0] idx_of(input logic [63:0] pc, input int unsigned idx_w);
      return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
   endfunction

   function automatic logic [63:0] tag_of(input logic [63:0] pc, input int unsigned idx_w);
      return pc >> (idx_w + 2);
   endfunction

endpackage

// File: rtl/btb_tagged_predictor_sat_counter.sv
// Combinational next value of a saturating up/down direction counter.
module sat_counter #(
   parameter int unsigned CTR_BITS = 2
) (
   input  logic [CTR_BITS-1:0] ctr_i,
   input  logic                inc_i,
   output logic [CTR_BITS-1:0] ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (inc_i) begin
         if (ctr_i != '1) ctr_o = ctr_i + CTR_BITS'(1);
      end else begin
         if (ctr_i != '0) ctr_o = ctr_i - CTR_BITS'(1);
      end
   end

endmodule

// File: rtl/btb_tagged_predictor.sv
// Direct-mapped tagged BTB: zero-latency fetch lookup, registered resolve-side
// update, whole-table flush, and a free-running hit counter.
module btb_tagged_predictor
   import btb_pkg::*;
#(
   parameter int unsigned XLEN     = BTB_XLEN,
   parameter int unsigned ENTRIES  = BTB_ENTRIES,
   parameter int unsigned CTR_BITS = BTB_CTR_BITS
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            lookup_en,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            pred_hit,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            upd_en,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            flush,
   output logic [31:0]     hit_count
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = XLEN - IDX_W - 2;

   btb_entry_t           table_q [ENTRIES];
   logic [ENTRIES-1:0]   valid_q, valid_d;
   logic [31:0]          hit_count_q;

   logic [IDX_W-1:0]     lk_idx, up_idx;
   logic [TAG_W-1:0]     lk_tag, up_tag;
   btb_entry_t           lk_e, up_e, wr_entry_d;
   logic                 up_hit, wr_en;
   logic [CTR_BITS-1:0]  ctr_nxt;

   assign lk_idx = IDX_W'(idx_of(64'(lookup_pc), IDX_W));
   assign lk_tag = TAG_W'(tag_of(64'(lookup_pc), IDX_W));
   assign up_idx = IDX_W'(idx_of(64'(upd_pc), IDX_W));
   assign up_tag = TAG_W'(tag_of(64'(upd_pc), IDX_W));

   // Valid lives in its own vector; the stored copy inside each entry is not authoritative.
   always_comb begin
      lk_e       = table_q[lk_idx];
      lk_e.valid = valid_q[lk_idx];
      pred_hit    = lookup_en & lk_e.valid & (lk_e.tag == lk_tag);
      pred_taken  = pred_hit & lk_e.ctr[CTR_BITS-1];
      pred_target = pred_hit ? lk_e.target : '0;
   end

   always_comb begin
      up_e       = table_q[up_idx];
      up_e.valid = valid_q[up_idx];
      up_hit     = up_e.valid & (up_e.tag == up_tag);
   end

   sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
      .ctr_i (up_e.ctr),
      .inc_i (upd_taken),
      .ctr_o (ctr_nxt)
   );

   always_comb begin
      valid_d    = valid_q;
      wr_en      = 1'b0;
      wr_entry_d = up_e;
      if (flush) begin
         valid_d = '0;
      end else if (upd_en) begin
         if (up_hit) begin
            wr_en          = 1'b1;
            wr_entry_d.ctr = ctr_nxt;
            if (upd_taken) wr_entry_d.target = upd_target;
         end else if (upd_taken) begin
            wr_en           = 1'b1;
            wr_entry_d      = '{valid: 1'b1, tag: up_tag, target: upd_target, ctr: CTR_WEAK_T};
            valid_d[up_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q     <= '0;
         hit_count_q <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
         end
      end else begin
         valid_q <= valid_d;
         if (wr_en) table_q[up_idx] <= wr_entry_d;
         if (pred_hit) hit_count_q <= hit_count_q + 32'd1;
      end
   end

   assign hit_count = hit_count_q;

endmodule
